// File: rtl/oled_char_gen_if.sv
// Char draw request / OLED byte-writer bundle seen by oled_char_gen.
// The draw_invert signal exists only when OLED_CHAR_INVERT_EN is defined.
interface oled_char_gen_if;
  logic       draw_start;
  logic [7:0] draw_ascii;
  logic [6:0] draw_x;
  logic [3:0] draw_y;
`ifdef OLED_CHAR_INVERT_EN
  logic       draw_invert;
`endif
  logic       draw_busy;
  logic       draw_done;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_dc;
  logic [7:0] wr_byte;

  // The glyph renderer: answers draw requests and drives the byte-writer.
  modport slave (
    input  draw_start,
    input  draw_ascii,
    input  draw_x,
    input  draw_y,
    input  wr_ready,
`ifdef OLED_CHAR_INVERT_EN
    input  draw_invert,
`endif
    output draw_busy,
    output draw_done,
    output wr_valid,
    output wr_dc,
    output wr_byte
  );

  // The requester mux plus byte-writer side.
  modport master (
    output draw_start,
    output draw_ascii,
    output draw_x,
    output draw_y,
    output wr_ready,
`ifdef OLED_CHAR_INVERT_EN
    output draw_invert,
`endif
    input  draw_busy,
    input  draw_done,
    input  wr_valid,
    input  wr_dc,
    input  wr_byte
  );
endinterface

// File: rtl/oled_char_gen.sv
// Renders one 8x16 font glyph into SSD1306 GDDRAM via page/column commands and data bytes.
// Optional OLED_CHAR_INVERT_EN: sends every data byte inverted when draw_invert was set.
module oled_char_gen #(
  parameter int FONT_AW  = 11,
  parameter int COL_MAX  = 127,
  parameter int PAGE_MAX = 7
) (
  input  logic               clk_50m,
  input  logic               rst,
  oled_char_gen_if.slave     bus,
  output logic [FONT_AW-1:0] rom_addr,
  input  logic [7:0]         rom_data
);

  localparam logic [7:0] COL_LIM  = 8'(COL_MAX);
  localparam logic [3:0] PAGE_LIM = 4'(PAGE_MAX);

  typedef enum logic [3:0] {
    IDLE,
    CMD_PAGE,
    CMD_COL_LO,
    CMD_COL_HI,
    ROM_RD,
    ROM_WAIT,
    DATA,
    NEXT_HALF,
    FINISH
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [6:0] idx_q;
  logic [6:0] x_q;
  logic [2:0] y_q;
  logic       half_q;
  logic       lower_q;
  logic [2:0] b_q;
  logic [7:0] data_q;
`ifdef OLED_CHAR_INVERT_EN
  logic       inv_q;
`endif

  logic       accept;
  logic       last_byte;
  logic [7:0] next_col;
  logic [2:0] page;
  logic [6:0] glyph_idx;

  // Non-printable codes fall back to the space glyph at index 0.
  always_comb begin
    glyph_idx = 7'd0;
    if (bus.draw_ascii >= 8'h20 && bus.draw_ascii <= 8'h7E)
      glyph_idx = bus.draw_ascii[6:0] - 7'h20;
  end

  assign accept    = (state == IDLE) && bus.draw_start;
  assign page      = y_q + {2'b00, half_q};
  assign next_col  = {1'b0, x_q} + {5'b00000, b_q} + 8'd1;
  assign last_byte = (b_q == 3'd7) || (next_col > COL_LIM);
  assign rom_addr  = FONT_AW'({idx_q, half_q, b_q});

  always_ff @(posedge clk_50m) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.draw_busy = 1'b1;
    bus.draw_done = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_dc     = 1'b0;
    bus.wr_byte   = 8'h00;
    case (state)
      IDLE: begin
        bus.draw_busy = 1'b0;
        if (bus.draw_start)
          state_nxt = (bus.draw_y > PAGE_LIM) ? NEXT_HALF : CMD_PAGE;
      end
      CMD_PAGE: begin
        bus.wr_valid = 1'b1;
        bus.wr_byte  = {5'b10110, page};
        if (bus.wr_ready)
          state_nxt = CMD_COL_LO;
      end
      CMD_COL_LO: begin
        bus.wr_valid = 1'b1;
        bus.wr_byte  = {4'h0, x_q[3:0]};
        if (bus.wr_ready)
          state_nxt = CMD_COL_HI;
      end
      CMD_COL_HI: begin
        bus.wr_valid = 1'b1;
        bus.wr_byte  = {5'b00010, x_q[6:4]};
        if (bus.wr_ready)
          state_nxt = ROM_RD;
      end
      ROM_RD:   state_nxt = ROM_WAIT;
      ROM_WAIT: state_nxt = DATA;
      DATA: begin
        bus.wr_valid = 1'b1;
        bus.wr_dc    = 1'b1;
        bus.wr_byte  = data_q;
        // Columns past the right edge are never read or written.
        if (bus.wr_ready) begin
          if (!last_byte)
            state_nxt = ROM_RD;
          else if (!half_q && lower_q)
            state_nxt = NEXT_HALF;
          else
            state_nxt = FINISH;
        end
      end
      NEXT_HALF: state_nxt = lower_q ? CMD_PAGE : FINISH;
      FINISH: begin
        bus.draw_busy = 1'b0;
        bus.draw_done = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, byte/half position tracking and ROM byte capture.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      half_q  <= 1'b0;
      lower_q <= 1'b0;
      b_q     <= '0;
      data_q  <= '0;
`ifdef OLED_CHAR_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        idx_q   <= glyph_idx;
        x_q     <= bus.draw_x;
        y_q     <= bus.draw_y[2:0];
        half_q  <= 1'b0;
        lower_q <= (bus.draw_y < PAGE_LIM);
        b_q     <= '0;
`ifdef OLED_CHAR_INVERT_EN
        inv_q   <= bus.draw_invert;
`endif
      end
      if (state == DATA && bus.wr_ready && !last_byte)
        b_q <= b_q + 3'd1;
      if (state == NEXT_HALF && lower_q) begin
        half_q  <= 1'b1;
        lower_q <= 1'b0;
        b_q     <= '0;
      end
      if (state == ROM_WAIT) begin
`ifdef OLED_CHAR_INVERT_EN
        data_q <= inv_q ? ~rom_data : rom_data;
`else
        data_q <= rom_data;
`endif
      end
    end
  end

endmodule
